ctrl_burst_act: RTL and testbench

Activate-stage controller of the DDR4 controller command path. It sits directly upstream of the CAS-timing stage. It accepts one decoded user request at a time and looks up the bank's open row. For a row hit it passes the request straight to the CAS stage; for a closed bank or a row conflict it issues PRECHARGE and/or ACTIVATE first. Every ACTIVATE is held back until tRP, tRRD and (optionally) tFAW are satisfied. Its `act_rdy` / `no_act_rdy` / `act_rw` outputs are exactly what the CAS stage consumes.

---
 rtl/ctrl_burst_act.sv | 226 ++++++++++++++++++++++
 tb/tb_ctrl_burst_act.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_burst_act.sv
// ---------------------------------------------------------------------------
// ddr_pkg     : request encoding shared by the command-path stages.
// ctrl_burst_act : activate stage of the DDR4 command path.
//
// Accepts one decoded request at a time and checks the bank's open row.
//   - row hit                 -> no_act_rdy strobe
//   - bank closed             -> act_rdy strobe once tRRD (and tFAW) allow
//   - row conflict            -> pre_rdy strobe, wait tRP, then act_rdy
// RDA_R / WRA_R close the bank after their hit or activate.
//
// Ports
//   CK_t, reset          clock (rising edge), async active-high reset
//   req_valid/req_rdy    request handshake
//   req_rw/bank/row      request fields (ddr_pkg encoding)
//   pre_rdy              one-cycle PRECHARGE strobe for cmd_bank
//   act_rdy              one-cycle ACTIVATE strobe (CAS stage applies tRCD)
//   no_act_rdy           one-cycle row-hit strobe
//   act_rw/cmd_bank/cmd_row  latched request, held until next transfer
//
// Build option: define ACT_TFAW_EN to add the four-activate-window gate.
// ---------------------------------------------------------------------------
package ddr_pkg;
  typedef enum logic [2:0] {
    NOP_R = 3'd0,
    RD_R  = 3'd1,
    RDA_R = 3'd2,
    WR_R  = 3'd3,
    WRA_R = 3'd4
  } req_rw_e;
endpackage

module ctrl_burst_act #(
  parameter int unsigned BANKS = 16,
  parameter int unsigned ROW_W = 17,
  parameter int unsigned tRP   = 11,
  parameter int unsigned tRRD  = 4,
  parameter int unsigned tFAW  = 20
) (
  input  logic                     CK_t,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_rdy,
  input  logic [2:0]               req_rw,
  input  logic [$clog2(BANKS)-1:0] req_bank,
  input  logic [ROW_W-1:0]         req_row,
  output logic                     pre_rdy,
  output logic                     act_rdy,
  output logic                     no_act_rdy,
  output logic [2:0]               act_rw,
  output logic [$clog2(BANKS)-1:0] cmd_bank,
  output logic [ROW_W-1:0]         cmd_row
);
  import ddr_pkg::*;

  localparam int unsigned BW = $clog2(BANKS);

  // tRP countdown is loaded in the PRECHARGE cycle; reaching zero in the
  // last wait cycle puts the ACTIVATE exactly tRP cycles after PRECHARGE.
  localparam int unsigned     TRP_W    = $clog2(tRP + 1);
  localparam logic [TRP_W-1:0] TRP_LOAD = TRP_W'(tRP - 2);

  // Cycles since the last ACTIVATE, saturating. The gate is evaluated one
  // cycle before the ACTIVATE state, hence the -1.
  localparam int unsigned      RRD_W    = $clog2(tRRD + 1);
  localparam logic [RRD_W-1:0] RRD_SAT  = RRD_W'(tRRD);
  localparam logic [RRD_W-1:0] RRD_GATE = RRD_W'(tRRD - 1);

  typedef enum logic [2:0] {
    ACT_IDLE,
    ACT_DECIDE,
    ACT_PRE,
    ACT_PRE_WAIT,
    ACT_WAIT,
    ACT_CMD,
    ACT_HIT
  } act_state_e;

  act_state_e state_q, state_d;

  logic [2:0]             rw_q, rw_d;
  logic [BW-1:0]          bank_q, bank_d;
  logic [ROW_W-1:0]       row_q, row_d;

  logic [BANKS-1:0]              valid_q, valid_d;
  logic [BANKS-1:0][ROW_W-1:0]   row_tbl_q, row_tbl_d;

  logic [TRP_W-1:0]       trp_q, trp_d;
  logic [RRD_W-1:0]       rrd_q, rrd_d;

  logic is_req, is_auto, rrd_ok, faw_ok, act_ok;

  assign is_req  = rw_q inside {RD_R, RDA_R, WR_R, WRA_R};
  assign is_auto = rw_q inside {RDA_R, WRA_R};
  assign rrd_ok  = rrd_q >= RRD_GATE;

`ifdef ACT_TFAW_EN
  localparam int unsigned      FAW_W    = $clog2(tFAW + 1);
  localparam logic [FAW_W-1:0] FAW_SAT  = FAW_W'(tFAW);
  localparam logic [FAW_W-1:0] FAW_GATE = FAW_W'(tFAW - 1);

  // Ages (cycles since) of the last four ACTIVATEs; [0] newest, [3] oldest.
  logic [3:0][FAW_W-1:0] faw_age_q, faw_age_d, faw_inc;

  always_comb begin
    faw_inc = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      faw_inc[i] = (faw_age_q[i] == FAW_SAT) ? FAW_SAT : faw_age_q[i] + FAW_W'(1);
    end
    if (state_q == ACT_CMD) begin
      faw_age_d = {faw_inc[2:0], FAW_W'(1)};
    end else begin
      faw_age_d = faw_inc;
    end
  end

  always_ff @(posedge CK_t or posedge reset) begin
    if (reset) begin
      faw_age_q <= {4{FAW_SAT}};
    end else begin
      faw_age_q <= faw_age_d;
    end
  end

  assign faw_ok = faw_age_q[3] >= FAW_GATE;
`else
  localparam int unsigned tfaw_unused = tFAW;
  assign faw_ok = 1'b1;
`endif

  assign act_ok = rrd_ok && faw_ok;

  // Strobes decode directly from state; req_rdy is masked by reset so it
  // stays low for the whole reset pulse.
  assign req_rdy    = (state_q == ACT_IDLE) && !reset;
  assign pre_rdy    = (state_q == ACT_PRE);
  assign act_rdy    = (state_q == ACT_CMD);
  assign no_act_rdy = (state_q == ACT_HIT);
  assign act_rw     = rw_q;
  assign cmd_bank   = bank_q;
  assign cmd_row    = row_q;

  always_comb begin
    state_d   = state_q;
    rw_d      = rw_q;
    bank_d    = bank_q;
    row_d     = row_q;
    valid_d   = valid_q;
    row_tbl_d = row_tbl_q;
    trp_d     = (trp_q == '0) ? '0 : trp_q - TRP_W'(1);
    rrd_d     = (rrd_q == RRD_SAT) ? RRD_SAT : rrd_q + RRD_W'(1);

    unique case (state_q)
      ACT_IDLE: begin
        if (req_valid && req_rdy) begin
          rw_d    = req_rw;
          bank_d  = req_bank;
          row_d   = req_row;
          state_d = ACT_DECIDE;
        end
      end
      ACT_DECIDE: begin
        if (!is_req) begin
          state_d = ACT_IDLE;
        end else if (valid_q[bank_q] && (row_tbl_q[bank_q] == row_q)) begin
          state_d = ACT_HIT;
        end else if (!valid_q[bank_q]) begin
          // Closed bank with open gates activates in the very next cycle.
          state_d = act_ok ? ACT_CMD : ACT_WAIT;
        end else begin
          state_d = ACT_PRE;
        end
      end
      ACT_PRE: begin
        valid_d[bank_q] = 1'b0;
        trp_d           = TRP_LOAD;
        state_d         = ACT_PRE_WAIT;
      end
      ACT_PRE_WAIT: begin
        if (trp_q == '0) begin
          state_d = act_ok ? ACT_CMD : ACT_WAIT;
        end
      end
      ACT_WAIT: begin
        if (act_ok) begin
          state_d = ACT_CMD;
        end
      end
      ACT_CMD: begin
        valid_d[bank_q]   = !is_auto;
        row_tbl_d[bank_q] = row_q;
        rrd_d             = RRD_W'(1);
        state_d           = ACT_IDLE;
      end
      ACT_HIT: begin
        if (is_auto) begin
          valid_d[bank_q] = 1'b0;
        end
        state_d = ACT_IDLE;
      end
      default: state_d = ACT_IDLE;
    endcase
  end

  always_ff @(posedge CK_t or posedge reset) begin
    if (reset) begin
      state_q   <= ACT_IDLE;
      rw_q      <= '0;
      bank_q    <= '0;
      row_q     <= '0;
      valid_q   <= '0;
      row_tbl_q <= '0;
      trp_q     <= '0;
      rrd_q     <= RRD_SAT;
    end else begin
      state_q   <= state_d;
      rw_q      <= rw_d;
      bank_q    <= bank_d;
      row_q     <= row_d;
      valid_q   <= valid_d;
      row_tbl_q <= row_tbl_d;
      trp_q     <= trp_d;
      rrd_q     <= rrd_d;
    end
  end

endmodule

// File: tb/tb_ctrl_burst_act.sv
// Scoreboard bench for ctrl_burst_act: stimulus pushes expected strobes
// (kind, cycle, latched fields) and a negedge monitor pops and compares.
module tb_ctrl_burst_act;
  import ddr_pkg::*;

  localparam int K_PRE = 0;
  localparam int K_ACT = 1;
  localparam int K_HIT = 2;
`ifdef ACT_TFAW_EN
  localparam int FIFTH_ACT = 21;
`else
  localparam int FIFTH_ACT = 17;
`endif

  logic        CK_t = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_rdy;
  logic [2:0]  req_rw = '0;
  logic [3:0]  req_bank = '0;
  logic [16:0] req_row = '0;
  logic        pre_rdy, act_rdy, no_act_rdy;
  logic [2:0]  act_rw;
  logic [3:0]  cmd_bank;
  logic [16:0] cmd_row;

  ctrl_burst_act #(.BANKS(16), .ROW_W(17), .tRP(11), .tRRD(4), .tFAW(20)) dut (
    .CK_t(CK_t), .reset(reset), .req_valid(req_valid), .req_rdy(req_rdy),
    .req_rw(req_rw), .req_bank(req_bank), .req_row(req_row),
    .pre_rdy(pre_rdy), .act_rdy(act_rdy), .no_act_rdy(no_act_rdy),
    .act_rw(act_rw), .cmd_bank(cmd_bank), .cmd_row(cmd_row)
  );

  always #5 CK_t = ~CK_t;

  int cyc = 0;
  always @(posedge CK_t) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void chk(string name, int actual, int expected);
    n_tests++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endfunction

  typedef struct {
    int kind;
    int at;
    int rw;
    int bank;
    int row;
  } exp_t;

  exp_t sb[$];

  function automatic void expect_ev(int kind, int at, int rw, int bank, int row);
    exp_t e;
    e.kind = kind; e.at = at; e.rw = rw; e.bank = bank; e.row = row;
    sb.push_back(e);
  endfunction

  // Monitor
  logic prev_strobe = 1'b0;
  always @(negedge CK_t) begin
    exp_t e;
    int   kind;
    if (!reset && (pre_rdy || act_rdy || no_act_rdy)) begin
      chk("strobe_onehot", int'(pre_rdy) + int'(act_rdy) + int'(no_act_rdy), 1);
      chk("strobe_gap", int'(prev_strobe), 0);
      kind = pre_rdy ? K_PRE : (act_rdy ? K_ACT : K_HIT);
      if (sb.size() == 0) begin
        chk("unexpected_strobe_kind", kind, -1);
      end else begin
        e = sb.pop_front();
        chk("strobe_kind", kind, e.kind);
        chk("strobe_cycle", cyc, e.at);
        chk("act_rw", int'(act_rw), e.rw);
        chk("cmd_bank", int'(cmd_bank), e.bank);
        chk("cmd_row", int'(cmd_row), e.row);
      end
    end
    prev_strobe <= pre_rdy | act_rdy | no_act_rdy;
  end

  // Called at a negedge; returns at the negedge of the request's cycle 0.
  task automatic send(input logic [2:0] rw, input int bank, input int row, output int t);
    int n;
    n = 0;
    while (!req_rdy && n < 100) begin
      @(negedge CK_t);
      n++;
    end
    chk("send_wait_rdy", int'(req_rdy), 1);
    req_valid = 1'b1;
    req_rw    = rw;
    req_bank  = 4'(bank);
    req_row   = 17'(row);
    @(negedge CK_t);
    t = cyc;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge CK_t);
      n++;
    end
    chk("scoreboard_drain", sb.size(), 0);
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = 1'b0;
    sb.delete();
    repeat (3) @(negedge CK_t);
    reset = 1'b0;
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_req_rdy"}, int'(req_rdy), 0);
    chk({tag, "_pre_rdy"}, int'(pre_rdy), 0);
    chk({tag, "_act_rdy"}, int'(act_rdy), 0);
    chk({tag, "_no_act_rdy"}, int'(no_act_rdy), 0);
    chk({tag, "_act_rw"}, int'(act_rw), 0);
    chk({tag, "_cmd_bank"}, int'(cmd_bank), 0);
    chk({tag, "_cmd_row"}, int'(cmd_row), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int t, t0;
    #2 reset = 1'b1;
    @(negedge CK_t);
    chk_all_zero("reset");
    do_reset();
    #1 chk("rdy_after_reset", int'(req_rdy), 1);

    // Closed bank activates in cycle 1; then hits, auto-precharge hit, reopen
    send(RD_R, 0, 5, t);
    expect_ev(K_ACT, t + 1, RD_R, 0, 5);
    send(WR_R, 0, 5, t);
    expect_ev(K_HIT, t + 1, WR_R, 0, 5);
    chk("hit_rdy_c0", int'(req_rdy), 0);
    @(negedge CK_t);
    chk("hit_rdy_c1", int'(req_rdy), 0);
    @(negedge CK_t);
    chk("hit_rdy_c2", int'(req_rdy), 1);
    send(WRA_R, 0, 5, t);
    expect_ev(K_HIT, t + 1, WRA_R, 0, 5);
    send(RD_R, 0, 5, t);
    expect_ev(K_ACT, t + 1, RD_R, 0, 5);
    drain();
    repeat (3) @(negedge CK_t);
    chk("hold_act_rw", int'(act_rw), RD_R);
    chk("hold_cmd_row", int'(cmd_row), 5);

    // Row conflict: PRE in cycle 1, ACT at cycle 1+tRP
    do_reset();
    send(RD_R, 2, 7, t);
    expect_ev(K_ACT, t + 1, RD_R, 2, 7);
    send(RD_R, 2, 9, t);
    expect_ev(K_PRE, t + 1, RD_R, 2, 9);
    expect_ev(K_ACT, t + 12, RD_R, 2, 9);
    drain();

    // Back-to-back to closed banks: tRRD spacing, then tFAW on the fifth
    do_reset();
    t0 = 0;
    for (int i = 0; i < 5; i++) begin
      send(RD_R, i, 16 + i, t);
      if (i == 0) t0 = t;
      expect_ev(K_ACT, (i < 4) ? t0 + 1 + 4 * i : t0 + FIFTH_ACT, RD_R, i, 16 + i);
    end
    drain();

    // Auto-precharge on activate: second access re-activates, no PRE
    do_reset();
    send(RDA_R, 3, 1, t);
    expect_ev(K_ACT, t + 1, RDA_R, 3, 1);
    send(RD_R, 3, 1, t);
    expect_ev(K_ACT, t + 2, RD_R, 3, 1);
    drain();

    // Non-request codes are discarded
    send(NOP_R, 4, 4, t);
    chk("nop_rdy_c0", int'(req_rdy), 0);
    @(negedge CK_t);
    chk("nop_rdy_c1", int'(req_rdy), 1);
    send(3'd6, 4, 4, t);
    chk("inv_rdy_c0", int'(req_rdy), 0);
    @(negedge CK_t);
    chk("inv_rdy_c1", int'(req_rdy), 1);
    repeat (4) @(negedge CK_t);

    // Reset in ACT_PRE_WAIT drops the request and clears the table
    do_reset();
    send(RD_R, 5, 3, t);
    expect_ev(K_ACT, t + 1, RD_R, 5, 3);
    send(RD_R, 2, 7, t);
    expect_ev(K_ACT, t + 2, RD_R, 2, 7);
    send(RD_R, 2, 9, t);
    expect_ev(K_PRE, t + 1, RD_R, 2, 9);
    repeat (5) @(negedge CK_t);
    chk("pre_popped", sb.size(), 0);
    reset = 1'b1;
    sb.delete();
    #1 chk_all_zero("midreset");
    repeat (2) @(negedge CK_t);
    reset = 1'b0;
    #1 chk("rdy_after_midreset", int'(req_rdy), 1);
    send(RD_R, 5, 3, t);
    expect_ev(K_ACT, t + 1, RD_R, 5, 3);
    send(RD_R, 2, 9, t);
    expect_ev(K_ACT, t + 2, RD_R, 2, 9);
    drain();

    repeat (20) @(negedge CK_t);
    chk("final_drain", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
